// File: rtl/johnson_phase_sched.sv
// Johnson ring phase generator shared among NREQ requesters through a round-robin arbiter.
// Optional illegal-pattern self-correction is enabled with `define JOHNSON_SELFCORRECT_EN.
//
// state | meaning
// IDLE  | ring parked at 0, arbitrating pending requests
// RUN   | ring stepping for the granted requester's burst
module johnson_phase_sched #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*CNT_W-1:0]       req_len,
    input  logic                        abort,
    output logic [NREQ-1:0]             gnt,
    output logic [WIDTH-1:0]            phase,
    output logic [$clog2(2*WIDTH)-1:0]  phase_idx,
    output logic                        busy,
    output logic [NREQ-1:0]             done,
    output logic                        err
);

    localparam int IDX_W = $clog2(2*WIDTH);
    localparam int RW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WIDTH-1:0] WRAP_VAL = WIDTH'(1) << (WIDTH-1);
    localparam logic [IDX_W:0]   SEQ_LEN  = (IDX_W+1)'(2*WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [RW-1:0]     last, cur, win;
    logic              any_req;
    logic [CNT_W-1:0]  len_sel, len_load, rot_cnt;
    logic              wrap, illegal;
    logic [WIDTH-1:0]  phase_step;
    logic [IDX_W:0]    pop, idx_ext;

    assign wrap       = (phase == WRAP_VAL);
    assign phase_step = {phase[WIDTH-2:0], ~phase[WIDTH-1]};

    // Round-robin search starting just after the last served requester.
    always_comb begin
        win     = last;
        any_req = |req;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[(int'(last) + i) % NREQ])
                win = RW'((int'(last) + i) % NREQ);
        end
    end

    assign len_sel  = req_len[int'(win)*CNT_W +: CNT_W];
    assign len_load = (len_sel == '0) ? CNT_W'(1) : len_sel;

    always_comb begin
        pop = '0;
        for (int k = 0; k < WIDTH; k++)
            pop = pop + {{IDX_W{1'b0}}, phase[k]};
        idx_ext   = phase[WIDTH-1] ? (SEQ_LEN - pop) : pop;
        phase_idx = idx_ext[IDX_W-1:0];
    end

`ifdef JOHNSON_SELFCORRECT_EN
    logic [WIDTH-1:0] legal_lo, legal_hi;

    // Legal words are a run of ones anchored at the LSB (MSB=0) or at the MSB (MSB=1).
    always_comb begin
        legal_lo = '0;
        legal_hi = '0;
        for (int k = 0; k < WIDTH; k++) begin
            legal_lo[k] = (k < int'(pop));
            legal_hi[k] = (k >= WIDTH - int'(pop));
        end
        illegal = phase[WIDTH-1] ? (phase != legal_hi) : (phase != legal_lo);
    end
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = RUN;
            RUN: begin
                if (abort || illegal)
                    state_nxt = IDLE;
                else if (wrap && rot_cnt <= CNT_W'(1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= '0;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            rot_cnt <= '0;
            last    <= RW'(NREQ-1);
            cur     <= '0;
        end else begin
            done <= '0;
            if (illegal)
                err <= 1'b1;
            if (state == IDLE) begin
                phase <= '0;
                if (any_req) begin
                    gnt     <= NREQ'(1) << win;
                    cur     <= win;
                    rot_cnt <= len_load;
                end
            end else if (abort || illegal) begin
                phase <= '0;
                gnt   <= '0;
                last  <= cur;
            end else begin
                phase <= phase_step;
                if (wrap) begin
                    if (rot_cnt <= CNT_W'(1)) begin
                        gnt  <= '0;
                        done <= NREQ'(1) << cur;
                        last <= cur;
                    end else begin
                        rot_cnt <= rot_cnt - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_phase_sched.sv
// Randomized bench for johnson_phase_sched against a burst-level reference model.
// Define JOHNSON_SELFCORRECT_EN for both bench and RTL to exercise the self-correct path.
module tb_johnson_phase_sched;

    localparam int WIDTH = 3;
    localparam int NREQ  = 4;
    localparam int CNT_W = 8;
    localparam int IDX_W = $clog2(2*WIDTH);
    localparam int SEQ   = 2*WIDTH;

    logic                    clk = 1'b0;
    logic                    rst, abort;
    logic [NREQ-1:0]         req;
    logic [NREQ*CNT_W-1:0]   req_len;
    logic [NREQ-1:0]         gnt, done;
    logic [WIDTH-1:0]        phase;
    logic [IDX_W-1:0]        phase_idx;
    logic                    busy, err;

    int checks   = 0;
    int failures = 0;

    // Reference model: whether a burst is active, whose, how many ring steps taken.
    bit m_run   = 1'b0;
    int m_owner = 0;
    int m_steps = 0;
    int m_len   = 1;
    int m_last  = NREQ-1;
    int m_done  = -1;
    bit m_err   = 1'b0;
    bit inj     = 1'b0;
    bit skip_phase = 1'b0;

    johnson_phase_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .abort(abort),
        .gnt(gnt), .phase(phase), .phase_idx(phase_idx), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Johnson word after i steps from zero: i ones filled from the LSB, then emptied from the LSB.
    function automatic logic [WIDTH-1:0] jval(input int i);
        int v;
        if (i <= WIDTH) v = (1 << i) - 1;
        else            v = ((1 << (SEQ - i)) - 1) << (i - WIDTH);
        return WIDTH'(v);
    endfunction

    task automatic model_edge();
        bit found;
        m_done = -1;
        if (rst) begin
            m_run = 0; m_steps = 0; m_last = NREQ-1; m_err = 0;
            return;
        end
        if (inj) m_err = 1;
        if (!m_run) begin
            if (req != '0) begin
                found = 0;
                for (int i = 1; i <= NREQ; i++) begin
                    if (!found && req[(m_last + i) % NREQ]) begin
                        m_owner = (m_last + i) % NREQ;
                        found = 1;
                    end
                end
                m_len = int'(req_len[m_owner*CNT_W +: CNT_W]);
                if (m_len == 0) m_len = 1;
                m_run = 1; m_steps = 0;
            end
        end else if (abort || inj) begin
            m_run = 0; m_steps = 0; m_last = m_owner;
        end else begin
            m_steps++;
            if (m_steps == SEQ * m_len) begin
                m_run = 0; m_steps = 0; m_done = m_owner; m_last = m_owner;
            end
        end
    endtask

    task automatic compare_all();
        chk_val("gnt",  gnt,  m_run ? (32'd1 << m_owner) : 32'd0);
        chk_val("busy", busy, m_run);
        chk_val("done", done, (m_done >= 0) ? (32'd1 << m_done) : 32'd0);
        chk_val("err",  err,  m_err);
        if (!skip_phase) begin
            chk_val("phase",     phase,     jval(m_steps % SEQ));
            chk_val("phase_idx", phase_idx, m_steps % SEQ);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        inj = 0;
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_len(input int r, input int v);
        req_len[r*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic count_burst(input logic [NREQ-1:0] who, output int ng, output int nd);
        ng = 0; nd = 0;
        for (int k = 0; k < 20; k++) begin
            if (gnt == who) ng++;
            if (done == who) nd++;
            step();
        end
    endtask

    initial begin
        logic [NREQ-1:0] rr_exp [4];
        int ng, nd, waited;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0001;

        rst = 1; req = '0; abort = 0; req_len = '0;
        step(); step();
        chk_val("rst_phase", phase, 0);
        chk_val("rst_gnt", gnt, 0);
        chk_val("rst_idx", phase_idx, 0);
        rst = 0;

        // Single burst of two rotations for requester 0.
        set_len(0, 2); req = 4'b0001;
        step();
        req = '0;
        count_burst(4'b0001, ng, nd);
        chk_val("burst_len", ng, 12);
        chk_val("burst_done", nd, 1);

        // Round robin from a fresh reset.
        rst = 1; step(); rst = 0;
        for (int r = 0; r < NREQ; r++) set_len(r, 1);
        req = 4'b1011;
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            while (gnt == '0 && waited < 20) begin step(); waited++; end
            chk_val("rr_wait", waited < 20, 1);
            chk_val("rr_order", gnt, rr_exp[g]);
            ng = 0;
            while (gnt == rr_exp[g] && ng < 20) begin step(); ng++; end
            chk_val("rr_len", ng, 6);
            chk_val("rr_gap", busy, 0);
        end
        req = '0;
        for (int k = 0; k < 8; k++) step();

        // Zero length counts as one rotation.
        set_len(2, 0); req = 4'b0100;
        step();
        req = '0;
        count_burst(4'b0100, ng, nd);
        chk_val("zero_len", ng, 6);
        chk_val("zero_done", nd, 1);

        // Abort during the third cycle of a 12-cycle burst for requester 1.
        set_len(1, 2); req = 4'b0010;
        step();
        req = 4'b0100; set_len(2, 1);
        step(); step();
        abort = 1;
        step();
        abort = 0;
        chk_val("abort_gnt", gnt, 0);
        chk_val("abort_phase", phase, 0);
        chk_val("abort_done", done, 0);
        step();
        chk_val("abort_next", gnt, 4'b0100);
        req = '0;
        for (int k = 0; k < 8; k++) step();

`ifdef JOHNSON_SELFCORRECT_EN
        set_len(0, 2); req = 4'b0001;
        step(); req = '0; step(); step();
        force dut.phase = 3'b101;
        inj = 1; skip_phase = 1;
        step();
        release dut.phase;
        chk_val("sc_err", err, 1);
        chk_val("sc_gnt", gnt, 0);
        chk_val("sc_done", done, 0);
        step();
        skip_phase = 0;
        chk_val("sc_phase", phase, 0);
        for (int k = 0; k < 5; k++) step();
        chk_val("sc_sticky", err, 1);
        rst = 1; step(); rst = 0;
        chk_val("sc_clear", err, 0);
`endif

        // Randomized traffic, lengths kept short so many bursts complete.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            abort = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) req = NREQ'($urandom);
            if ($urandom_range(0, 3) == 0)
                for (int r = 0; r < NREQ; r++) set_len(r, $urandom_range(0, 3));
            step();
        end
        rst = 0; abort = 0; req = '0;
        for (int k = 0; k < 30; k++) step();
`ifndef JOHNSON_SELFCORRECT_EN
        chk_val("err_tied", err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/johnson_phase_sched.md
Name: johnson_phase_sched

Overview:
- Owns a WIDTH-bit Johnson ring phase generator (2*WIDTH states) and shares it among NREQ requesters.
- Each requester asks for a burst of N full ring rotations.
- A round-robin arbiter grants one requester at a time; the ring advances only while a burst runs.
- Sits between the phase-consuming datapath blocks and the ring; it is the only block that starts, stops or resets the ring.

Parameters:
- WIDTH, 3, ring width; sequence length 2*WIDTH
- NREQ, 4, number of requesters
- CNT_W, 8, width of the per-requester rotation count

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  level request, one bit per requester
- req_len  input  NREQ*CNT_W  rotations requested; requester i uses bits [i*CNT_W +: CNT_W]
- abort  input  1  terminates the current burst
- gnt  output  NREQ  one-hot grant, held for the whole burst
- phase  output  WIDTH  Johnson ring value
- phase_idx  output  $clog2(2*WIDTH)  decoded ring position, 0..2*WIDTH-1
- busy  output  1  high in RUN
- done  output  NREQ  one-cycle completion pulse to the finished requester
- err  output  1  sticky illegal-pattern flag

Behaviour:
- Reset, when rst is high at a clock edge:
  - state=IDLE, phase=0, gnt=0, busy=0, done=0, err=0, rot_cnt=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- Ring step, taken only in RUN: phase[0] <= ~phase[WIDTH-1]; phase[k] <= phase[k-1] for k=1..WIDTH-1.
  - WIDTH=3 sequence: 000,001,011,111,110,100,000.
- phase_idx decode, combinational from phase:
  - MSB=0: phase_idx = popcount(phase).
  - MSB=1: phase_idx = 2*WIDTH - popcount(phase).
- IDLE:
  - phase held at 0; busy=0.
  - If any req is high at an edge, the winner is the first set bit searching from last+1 with wrap.
  - On that edge: gnt <= onehot(winner), rot_cnt <= req_len[winner] (a value of 0 is loaded as 1), state <= RUN.
  - Latency: req seen at edge t gives gnt and busy high from t+1; the ring first steps at edge t+1.
- RUN:
  - The ring steps every cycle; gnt stays stable; req changes are ignored.
  - Wrap edge: phase == {1,0..0}, so the ring returns to 0.
  - At a wrap edge with rot_cnt>1: rot_cnt decrements.
  - At a wrap edge with rot_cnt==1: state <= IDLE, gnt <= 0, done[winner] pulses for exactly the next cycle, last <= winner.
  - A burst holds gnt for exactly 2*WIDTH*L cycles, where L is the loaded count.
  - Back-to-back bursts have exactly one IDLE cycle between them; done coincides with that IDLE cycle.
- abort:
  - Acts only in RUN; ignored in IDLE.
  - Next edge: phase <= 0, state <= IDLE, gnt <= 0, no done pulse, last <= winner.
  - If abort is high on the same edge as the final wrap, abort wins: no done.
- rst mid-burst: immediate return to the reset values above; no done pulse.
- req_len is sampled only at grant; later changes have no effect on the burst in progress.

Optional Feature:
- Macro: JOHNSON_SELFCORRECT_EN.
- Defined:
  - Every cycle, phase is checked against the legal Johnson set: 1s contiguous from the LSB (MSB=0), or 1s contiguous from the MSB (MSB=1).
  - On an illegal pattern, at the next edge: err <= 1 (sticky until rst), phase <= 0.
  - If the illegal pattern occurs in RUN, the burst ends exactly as an abort.
- Undefined: no checking; err is tied to 0.

Test Plan:
- Reset: assert rst for 2 cycles -> phase=000, gnt=0000, busy=0, done=0000, err=0, phase_idx=0.
- Single burst:
  - Stimulus: req=0001, req_len[0]=2, WIDTH=3.
  - gnt=0001 for exactly 12 cycles.
  - phase visits 001,011,111,110,100,000 twice, with phase_idx 1,2,3,4,5,0.
  - done=0001 for 1 cycle, then IDLE.
- Round-robin:
  - Stimulus: req=1011 held high, all lengths=1.
  - Grant order is 0001,0010,1000,0001.
  - Each grant lasts 6 cycles, with a 1-cycle IDLE gap between grants.
- Zero length: req=0100, req_len[2]=0 -> treated as 1 rotation: 6 cycles, then done=0100.
- Abort:
  - Stimulus: abort at cycle 3 of a 12-cycle burst for requester 1.
  - Next cycle: phase=000, gnt=0, no done.
  - Next grant goes to requester 2 if it is requesting.
- Self-correct, with JOHNSON_SELFCORRECT_EN defined:
  - Stimulus: force phase=101 for 1 cycle in RUN.
  - Next cycle: err=1, phase=000, gnt=0, no done; err stays 1 until rst.
  - With the macro undefined: err stays 0.
